// File: rtl/tetris_banner_pkg.sv
// tetris_banner_pkg
//   Shared definitions for the title banner: 4:4:4 colour type, the six
//   10x10 glyph bitmaps spelling "TETRIS" (bit 9 = leftmost column, row 0 =
//   top), the six-entry rotation palette and lookup helpers.
package tetris_banner_pkg;

  typedef logic [11:0] rgb_t;

  localparam int unsigned PKG_GLYPH_W    = 10;
  localparam int unsigned PKG_GLYPH_H    = 10;
  localparam int unsigned PKG_NUM_GLYPHS = 6;
  localparam int unsigned PKG_NUM_COLORS = 6;
  localparam int unsigned PKG_RW         = $clog2(PKG_GLYPH_H);
  localparam int unsigned PKG_PW         = $clog2(PKG_NUM_COLORS);

  typedef logic [PKG_GLYPH_W-1:0] glyph_row_t;
  typedef logic [0:PKG_GLYPH_H-1][PKG_GLYPH_W-1:0] glyph_bitmap_t;

  localparam glyph_bitmap_t GLYPH_T = {
    10'b1111111111, 10'b1111111111, 10'b0000110000, 10'b0000110000,
    10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
    10'b0000110000, 10'b0000110000};

  localparam glyph_bitmap_t GLYPH_E = {
    10'b0111111110, 10'b0111111110, 10'b0110000000, 10'b0110000000,
    10'b0111111100, 10'b0111111100, 10'b0110000000, 10'b0110000000,
    10'b0111111110, 10'b0111111110};

  localparam glyph_bitmap_t GLYPH_R = {
    10'b0111111100, 10'b0111111110, 10'b0110000110, 10'b0110000110,
    10'b0111111100, 10'b0111111000, 10'b0110011000, 10'b0110001100,
    10'b0110000110, 10'b0110000110};

  localparam glyph_bitmap_t GLYPH_I = {
    10'b0111111110, 10'b0111111110, 10'b0000110000, 10'b0000110000,
    10'b0000110000, 10'b0000110000, 10'b0000110000, 10'b0000110000,
    10'b0111111110, 10'b0111111110};

  localparam glyph_bitmap_t GLYPH_S = {
    10'b0011111110, 10'b0111111110, 10'b0110000000, 10'b0111111100,
    10'b0011111110, 10'b0000000110, 10'b0000000110, 10'b0111111110,
    10'b0111111100, 10'b0000000000};

  localparam logic [0:PKG_NUM_COLORS-1][11:0] PALETTE = {
    12'hf00, 12'hf70, 12'hff0, 12'h7f0, 12'h0df, 12'he5f};

  // Row r of glyph g of the word "TETRIS"; zero outside the bitmap set.
  function automatic glyph_row_t glyph_bitmap_row(input int unsigned g,
                                                  input int unsigned r);
    glyph_row_t         row;
    logic [PKG_RW-1:0]  ri;
    row = '0;
    ri  = PKG_RW'(r);
    if (r < PKG_GLYPH_H) begin
      case (g)
        0:       row = GLYPH_T[ri];
        1:       row = GLYPH_E[ri];
        2:       row = GLYPH_T[ri];
        3:       row = GLYPH_R[ri];
        4:       row = GLYPH_I[ri];
        5:       row = GLYPH_S[ri];
        default: row = '0;
      endcase
    end
    return row;
  endfunction

  function automatic rgb_t palette_color(input int unsigned idx);
    logic [PKG_PW-1:0] pi;
    pi = PKG_PW'(idx % PKG_NUM_COLORS);
    return PALETTE[pi];
  endfunction

endpackage

// File: rtl/banner_glyph_rom.sv
// banner_glyph_rom
//   Combinational glyph row lookup.
//   glyph : glyph index (0 = leftmost letter)
//   row   : bitmap row (0 = top)
//   bits  : GLYPH_W-bit row, bit GLYPH_W-1 = leftmost column; all zero when
//           glyph >= NUM_GLYPHS or row >= GLYPH_H.
module banner_glyph_rom
  import tetris_banner_pkg::*;
#(
  parameter int unsigned NUM_GLYPHS = 6,
  parameter int unsigned GLYPH_W    = 10,
  parameter int unsigned GLYPH_H    = 10,
  parameter int unsigned GW         = 3,
  parameter int unsigned RW         = 4
) (
  input  logic [GW-1:0]      glyph,
  input  logic [RW-1:0]      row,
  output logic [GLYPH_W-1:0] bits
);

  glyph_row_t src;

  always_comb begin
    bits = '0;
    src  = glyph_bitmap_row(32'(glyph), 32'(row));
    if ((32'(glyph) < NUM_GLYPHS) && (32'(row) < GLYPH_H)) begin
      // Left-align the stored bitmap into the configured glyph width.
      for (int unsigned i = 0; i < GLYPH_W; i++) begin
        if (i < PKG_GLYPH_W) bits[GLYPH_W-1-i] = src[PKG_GLYPH_W-1-i];
      end
    end
  end

endmodule

// File: rtl/title_banner_renderer.sv
// title_banner_renderer
//   Two-stage pixel pipeline drawing the "TETRIS" title banner, each glyph
//   magnified by SCALE, with optional per-glyph colour rotation.
//   Clk          : clock, all state on rising edge
//   Reset        : asynchronous, active-high
//   DrawX/DrawY  : current pixel column/row
//   pixel_valid  : DrawX/DrawY valid this cycle
//   frame_start  : one-cycle pulse at start of each frame
//   banner_valid : pixel_valid delayed two cycles
//   banner_on    : pixel lies on a lit glyph bit
//   banner_rgb   : 4:4:4 colour, 12'h000 when banner_on = 0
//   Define BANNER_COLOR_CYCLE_EN to rotate the palette by one entry every
//   FRAMES_PER_STEP frames; otherwise frame_start is ignored.
module title_banner_renderer
  import tetris_banner_pkg::*;
#(
  parameter int unsigned NUM_GLYPHS      = 6,
  parameter int unsigned GLYPH_W         = 10,
  parameter int unsigned GLYPH_H         = 10,
  parameter int unsigned SCALE           = 3,
  parameter int unsigned ORIGIN_X        = 400,
  parameter int unsigned ORIGIN_Y        = 40,
  parameter int unsigned NUM_COLORS      = 6,
  parameter int unsigned FRAMES_PER_STEP = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  input  logic       pixel_valid,
  input  logic       frame_start,
  output logic       banner_valid,
  output logic       banner_on,
  output rgb_t       banner_rgb
);

  localparam int unsigned GLYPH_PIX_W = GLYPH_W * SCALE;
  localparam int unsigned BOX_W       = NUM_GLYPHS * GLYPH_PIX_W;
  localparam int unsigned BOX_H       = GLYPH_H * SCALE;
  localparam int unsigned GW = (NUM_GLYPHS > 1) ? $clog2(NUM_GLYPHS) : 1;
  localparam int unsigned CW = (GLYPH_W    > 1) ? $clog2(GLYPH_W)    : 1;
  localparam int unsigned RW = (GLYPH_H    > 1) ? $clog2(GLYPH_H)    : 1;
  localparam int unsigned OW = (NUM_COLORS > 1) ? $clog2(NUM_COLORS) : 1;

  if (SCALE < 1 || SCALE > 8) begin : g_bad_scale
    $error("SCALE must be within 1..8");
  end

  // ---------------------------------------------------------------------
  // Colour rotation offset
  // ---------------------------------------------------------------------
  logic [OW-1:0] offset;

`ifdef BANNER_COLOR_CYCLE_EN
  localparam int unsigned FW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  logic [FW-1:0] frame_cnt;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      frame_cnt <= '0;
      offset    <= '0;
    end else if (frame_start) begin
      if (32'(frame_cnt) == FRAMES_PER_STEP - 1) begin
        frame_cnt <= '0;
        offset    <= (32'(offset) == NUM_COLORS - 1) ? '0 : offset + 1'b1;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end
`else
  localparam int unsigned unused_frames_per_step = FRAMES_PER_STEP;
  logic unused_frame_start;

  assign unused_frame_start = frame_start;
  assign offset             = '0;
`endif

  // ---------------------------------------------------------------------
  // Stage 1: box test and glyph/column/row decomposition
  // ---------------------------------------------------------------------
  logic [31:0]   x32, y32, dx, dy;
  logic          in_box;
  logic [GW-1:0] g_n;
  logic [CW-1:0] c_n;
  logic [RW-1:0] r_n;

  always_comb begin
    x32    = 32'(DrawX);
    y32    = 32'(DrawY);
    dx     = '0;
    dy     = '0;
    g_n    = '0;
    c_n    = '0;
    r_n    = '0;
    // Lower bounds are tested before any subtraction so an unsigned
    // wrap-around can never map a pixel left of/above the origin in-box.
    in_box = (x32 >= ORIGIN_X) && (x32 < ORIGIN_X + BOX_W) &&
             (y32 >= ORIGIN_Y) && (y32 < ORIGIN_Y + BOX_H);
    if (in_box) begin
      dx  = x32 - ORIGIN_X;
      dy  = y32 - ORIGIN_Y;
      g_n = GW'(dx / GLYPH_PIX_W);
      c_n = CW'((dx % GLYPH_PIX_W) / SCALE);
      r_n = RW'(dy / SCALE);
    end
  end

  logic          s1_valid;
  logic          s1_inbox;
  logic [GW-1:0] s1_g;
  logic [CW-1:0] s1_c;
  logic [RW-1:0] s1_r;
  logic [OW-1:0] s1_off;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid <= 1'b0;
      s1_inbox <= 1'b0;
      s1_g     <= '0;
      s1_c     <= '0;
      s1_r     <= '0;
      s1_off   <= '0;
    end else begin
      s1_valid <= pixel_valid;
      s1_inbox <= pixel_valid & in_box;
      s1_g     <= g_n;
      s1_c     <= c_n;
      s1_r     <= r_n;
      s1_off   <= offset;
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2: bitmap fetch, column select, colour
  // ---------------------------------------------------------------------
  logic [GLYPH_W-1:0] rom_bits;
  logic [GLYPH_W-1:0] rom_rev;
  logic               lit;
  rgb_t               glyph_rgb;

  banner_glyph_rom #(
    .NUM_GLYPHS (NUM_GLYPHS),
    .GLYPH_W    (GLYPH_W),
    .GLYPH_H    (GLYPH_H),
    .GW         (GW),
    .RW         (RW)
  ) u_rom (
    .glyph (s1_g),
    .row   (s1_r),
    .bits  (rom_bits)
  );

  always_comb begin
    // Reverse so that column index c addresses bit c directly.
    rom_rev = '0;
    for (int unsigned i = 0; i < GLYPH_W; i++) begin
      rom_rev[i] = rom_bits[GLYPH_W-1-i];
    end
    lit       = s1_valid & s1_inbox & rom_rev[s1_c];
    glyph_rgb = palette_color((32'(s1_g) + 32'(s1_off)) % NUM_COLORS);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      banner_valid <= 1'b0;
      banner_on    <= 1'b0;
      banner_rgb   <= '0;
    end else begin
      banner_valid <= s1_valid;
      banner_on    <= lit;
      banner_rgb   <= lit ? glyph_rgb : '0;
    end
  end

endmodule

// File: tb/tb_title_banner_renderer.sv
// Bench for title_banner_renderer: reference model draws the banner from
// ASCII-art glyphs and computes colour from the frame pulse count.
module tb_title_banner_renderer;

  localparam int OX = 400, OY = 40, SC = 3, GWD = 10, GHT = 10, NG = 6;
  localparam int NC = 6, FPS = 30;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic [9:0] DrawX = '0, DrawY = '0;
  logic       pixel_valid = 1'b0, frame_start = 1'b0;
  logic       banner_valid, banner_on;
  logic [11:0] banner_rgb;

  title_banner_renderer dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .DrawX        (DrawX),
    .DrawY        (DrawY),
    .pixel_valid  (pixel_valid),
    .frame_start  (frame_start),
    .banner_valid (banner_valid),
    .banner_on    (banner_on),
    .banner_rgb   (banner_rgb)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        v;
    logic        on;
    logic [11:0] rgb;
  } exp_t;

  string art [6][10] = '{
    '{"##########", "##########", "....##....", "....##....", "....##....",
      "....##....", "....##....", "....##....", "....##....", "....##...."},
    '{".########.", ".########.", ".##.......", ".##.......", ".#######..",
      ".#######..", ".##.......", ".##.......", ".########.", ".########."},
    '{"##########", "##########", "....##....", "....##....", "....##....",
      "....##....", "....##....", "....##....", "....##....", "....##...."},
    '{".#######..", ".########.", ".##....##.", ".##....##.", ".#######..",
      ".######...", ".##..##...", ".##...##..", ".##....##.", ".##....##."},
    '{".########.", ".########.", "....##....", "....##....", "....##....",
      "....##....", "....##....", "....##....", ".########.", ".########."},
    '{"..#######.", ".########.", ".##.......", ".#######..", "..#######.",
      ".......##.", ".......##.", ".########.", ".#######..", ".........."}
  };
  logic [11:0] pal [6] = '{12'hf00, 12'hf70, 12'hff0, 12'h7f0, 12'h0df, 12'he5f};

  int n_cmp = 0, n_bad = 0;
  int fs_count = 0;
  logic        obs_v, obs_on;
  logic [11:0] obs_rgb;

  function automatic int cur_offset();
`ifdef BANNER_COLOR_CYCLE_EN
    return (fs_count / FPS) % NC;
`else
    return 0;
`endif
  endfunction

  function automatic exp_t model(int x, int y, logic v, int off);
    exp_t e;
    int g, c, r;
    string row;
    e = '{1'b0, 1'b0, 12'h000};
    if (!v) return e;
    e.v = 1'b1;
    if (x < OX || x >= OX + NG * GWD * SC || y < OY || y >= OY + GHT * SC) return e;
    g   = (x - OX) / (GWD * SC);
    c   = ((x - OX) % (GWD * SC)) / SC;
    r   = (y - OY) / SC;
    row = art[g][r];
    if (row[c] == "#") begin
      e.on  = 1'b1;
      e.rgb = pal[(g + off) % NC];
    end
    return e;
  endfunction

  // Drive one cycle of inputs and sample outputs #1 after the edge.
  task automatic cycle(input int x, input int y, input logic v, input logic fs);
    DrawX       = 10'(x);
    DrawY       = 10'(y);
    pixel_valid = v;
    frame_start = fs;
    @(posedge Clk);
    if (fs) fs_count++;
    #1;
    obs_v   = banner_valid;
    obs_on  = banner_on;
    obs_rgb = banner_rgb;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle(OX, OY, 1'b1, 1'b0);
      n_cmp++;
      if (obs_v !== 1'b0 || obs_on !== 1'b0 || obs_rgb !== 12'h000) begin
        n_bad++;
        $display("FAIL reset_hold i=%0d got v=%0b on=%0b rgb=%h want 0/0/000", i, obs_v, obs_on, obs_rgb);
      end
    end
    Reset    = 1'b0;
    fs_count = 0;
    cycle(OX, OY, 1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== 1'b0 || obs_on !== 1'b0 || obs_rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL reset_first got v=%0b on=%0b rgb=%h want 0/0/000", obs_v, obs_on, obs_rgb);
    end
    cycle(0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_v !== 1'b1 || obs_on !== 1'b1 || obs_rgb !== 12'hf00) begin
      n_bad++;
      $display("FAIL reset_origin got v=%0b on=%0b rgb=%h want 1/1/f00", obs_v, obs_on, obs_rgb);
    end
  endtask

  task automatic test_directed();
    int   xs [12] = '{400, 399, 400, 430, 433, 400, 579, 580, 400, 579, 400, 0};
    int   ys [12] = '{ 40,  40,  70,  40,  40,  39,  40,  40,  69,  69,  40, 0};
    logic vs [12] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 0, 1};
    exp_t prev, cur;
    prev = '{1'b0, 1'b0, 12'h000};
    for (int i = 0; i <= 12; i++) begin
      if (i < 12) begin
        cur = model(xs[i], ys[i], vs[i], cur_offset());
        cycle(xs[i], ys[i], vs[i], 1'b0);
      end else begin
        cur = '{1'b0, 1'b0, 12'h000};
        cycle(0, 0, 1'b0, 1'b0);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_v !== prev.v || obs_on !== prev.on || obs_rgb !== prev.rgb) begin
          n_bad++;
          $display("FAIL directed (%0d,%0d) got v=%0b on=%0b rgb=%h want v=%0b on=%0b rgb=%h",
                   xs[i-1], ys[i-1], obs_v, obs_on, obs_rgb, prev.v, prev.on, prev.rgb);
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_back_to_back();
    exp_t prev, cur;
    int   lit_cnt;
    lit_cnt = 0;
    prev = '{1'b0, 1'b0, 12'h000};
    for (int i = 0; i <= 180; i++) begin
      if (i < 180) begin
        cur = model(OX + i, OY, 1'b1, cur_offset());
        cycle(OX + i, OY, 1'b1, 1'b0);
      end else begin
        cur = '{1'b0, 1'b0, 12'h000};
        cycle(0, 0, 1'b0, 1'b0);
      end
      if (i > 0) begin
        if (obs_on === 1'b1) lit_cnt++;
        n_cmp++;
        if (obs_v !== prev.v || obs_on !== prev.on || obs_rgb !== prev.rgb) begin
          n_bad++;
          $display("FAIL b2b x=%0d got v=%0b on=%0b rgb=%h want v=%0b on=%0b rgb=%h",
                   OX + i - 1, obs_v, obs_on, obs_rgb, prev.v, prev.on, prev.rgb);
        end
      end
      prev = cur;
    end
    // Row 0 lit columns: T10 E8 T10 R7 I8 S7 = 50 columns, x3 magnification.
    n_cmp++;
    if (lit_cnt != 150) begin
      n_bad++;
      $display("FAIL b2b_lit_count got %0d want 150", lit_cnt);
    end
  endtask

  task automatic test_random();
    exp_t prev, cur;
    int   x, y, px, py;
    logic v, fs;
    prev = '{1'b0, 1'b0, 12'h000};
    px = 0;
    py = 0;
    for (int i = 0; i <= 400; i++) begin
      if (i < 400) begin
        x   = 380 + int'($urandom_range(0, 220));
        y   = 30 + int'($urandom_range(0, 50));
        v   = ($urandom_range(0, 3) != 0);
        fs  = ($urandom_range(0, 7) == 0);
        cur = model(x, y, v, cur_offset());
        cycle(x, y, v, fs);
      end else begin
        x = 0;
        y = 0;
        cur = '{1'b0, 1'b0, 12'h000};
        cycle(0, 0, 1'b0, 1'b0);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_v !== prev.v || obs_on !== prev.on || obs_rgb !== prev.rgb) begin
          n_bad++;
          $display("FAIL random (%0d,%0d) got v=%0b on=%0b rgb=%h want v=%0b on=%0b rgb=%h",
                   px, py, obs_v, obs_on, obs_rgb, prev.v, prev.on, prev.rgb);
        end
      end
      prev = cur;
      px   = x;
      py   = y;
    end
  endtask

  task automatic test_color_cycle();
    int   xs[$], ys[$];
    logic vs[$], fss[$];
    exp_t prev, cur;
    int   n;
    Reset = 1'b1;
    cycle(0, 0, 1'b0, 1'b0);
    Reset    = 1'b0;
    fs_count = 0;
    // 30 pulses, pixel, 150 pulses, pixel, 29 pulses, pixel with pulse, pixel.
    for (int i = 0; i < 30; i++) begin xs.push_back(0); ys.push_back(0); vs.push_back(0); fss.push_back(1); end
    xs.push_back(OX); ys.push_back(OY); vs.push_back(1); fss.push_back(0);
    for (int i = 0; i < 150; i++) begin xs.push_back(0); ys.push_back(0); vs.push_back(0); fss.push_back(1); end
    xs.push_back(OX); ys.push_back(OY); vs.push_back(1); fss.push_back(0);
    for (int i = 0; i < 29; i++) begin xs.push_back(0); ys.push_back(0); vs.push_back(0); fss.push_back(1); end
    xs.push_back(OX); ys.push_back(OY); vs.push_back(1); fss.push_back(1);
    xs.push_back(OX + 33); ys.push_back(OY); vs.push_back(1); fss.push_back(0);
    n = xs.size();
    prev = '{1'b0, 1'b0, 12'h000};
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        cur = model(xs[i], ys[i], vs[i], cur_offset());
        cycle(xs[i], ys[i], vs[i], fss[i]);
      end else begin
        cur = '{1'b0, 1'b0, 12'h000};
        cycle(0, 0, 1'b0, 1'b0);
      end
      if (i > 0) begin
        n_cmp++;
        if (obs_v !== prev.v || obs_on !== prev.on || obs_rgb !== prev.rgb) begin
          n_bad++;
          $display("FAIL color_cycle step=%0d got v=%0b on=%0b rgb=%h want v=%0b on=%0b rgb=%h",
                   i - 1, obs_v, obs_on, obs_rgb, prev.v, prev.on, prev.rgb);
        end
      end
      prev = cur;
    end
  endtask

  task automatic test_reset_inflight();
    for (int i = 0; i < 30; i++) cycle(0, 0, 1'b0, 1'b1);
    cycle(OX, OY, 1'b1, 1'b0);
    DrawX       = 10'(OX + 3);
    DrawY       = 10'(OY);
    pixel_valid = 1'b1;
    Reset       = 1'b1;
    #1;
    n_cmp++;
    if (banner_valid !== 1'b0 || banner_on !== 1'b0 || banner_rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL inflight_async got v=%0b on=%0b rgb=%h want 0/0/000", banner_valid, banner_on, banner_rgb);
    end
    cycle(OX + 3, OY, 1'b1, 1'b0);
    n_cmp++;
    if (obs_v !== 1'b0 || obs_on !== 1'b0 || obs_rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL inflight_hold got v=%0b on=%0b rgb=%h want 0/0/000", obs_v, obs_on, obs_rgb);
    end
    Reset    = 1'b0;
    fs_count = 0;
    cycle(0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_v !== 1'b0 || obs_on !== 1'b0 || obs_rgb !== 12'h000) begin
      n_bad++;
      $display("FAIL inflight_drained got v=%0b on=%0b rgb=%h want 0/0/000", obs_v, obs_on, obs_rgb);
    end
    cycle(OX, OY, 1'b1, 1'b0);
    cycle(0, 0, 1'b0, 1'b0);
    n_cmp++;
    if (obs_v !== 1'b1 || obs_on !== 1'b1 || obs_rgb !== 12'hf00) begin
      n_bad++;
      $display("FAIL inflight_offset0 got v=%0b on=%0b rgb=%h want 1/1/f00", obs_v, obs_on, obs_rgb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_random();
    test_color_cycle();
    test_reset_inflight();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
